// File: rtl/dt1_rv_pkg.sv
// rtl/dt1_rv_pkg.sv - shared writeback contract: widths, x0 address, ResultSrc encoding
package dt1_rv_pkg;

  localparam int          XLEN     = 32;
  localparam int          REG_AW   = 5;
  localparam int          NREGS    = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Any ResultSrc with bit 1 set selects PC+4.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

endpackage

// File: rtl/dt1_instret_counter.sv
// rtl/dt1_instret_counter.sv - retired-instruction up-counter, wraps silently
module dt1_instret_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/dt1_regfile_wb.sv
// rtl/dt1_regfile_wb.sv - integer register file at the writeback end, with WB->D bypass
module dt1_regfile_wb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RegWriteW,
  input  logic [dt1_rv_pkg::REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]               ResultW,
  input  logic                          ValidW,
  input  logic [dt1_rv_pkg::REG_AW-1:0] Rs1D,
  input  logic [dt1_rv_pkg::REG_AW-1:0] Rs2D,
  output logic [XLEN-1:0]               RD1D,
  output logic [XLEN-1:0]               RD2D,
  input  logic [dt1_rv_pkg::REG_AW-1:0] DbgAddr,
  output logic [XLEN-1:0]               DbgData,
  output logic [CNT_W-1:0]              InstRetW
);

  import dt1_rv_pkg::*;

  // x0 has no storage; index 0 is never addressed.
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic            we;

  // Gating with reset keeps a pending write invisible on the read ports too.
  assign we = RegWriteW && (RdW != REG_ZERO) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[RdW] <= ResultW;
    end
  end

  always_comb begin
    RD1D = '0;
    if (Rs1D != REG_ZERO) begin
      if ((BYPASS != 0) && we && (RdW == Rs1D)) RD1D = ResultW;
      else                                      RD1D = regs_q[Rs1D];
    end
  end

  always_comb begin
    RD2D = '0;
    if (Rs2D != REG_ZERO) begin
      if ((BYPASS != 0) && we && (RdW == Rs2D)) RD2D = ResultW;
      else                                      RD2D = regs_q[Rs2D];
    end
  end

  always_comb begin
    DbgData = '0;
    if (DbgAddr != REG_ZERO) DbgData = regs_q[DbgAddr];
  end

  dt1_instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ValidW),
    .count_o (InstRetW)
  );

endmodule
